// File: rtl/button_event_pkg.sv
// Shared state encoding and 25 MHz timing defaults for the button event decoder.
// BUTTON_EVENT_DOUBLE_CLICK_EN adds the double-click states to the encoding.
package button_event_pkg;

   localparam int unsigned DEF_LONG_PRESS_TIME     = 25_000_000;
   localparam int unsigned DEF_DOUBLE_CLICK_WINDOW = 7_500_000;
   localparam int unsigned DEF_CNT_WIDTH           = 25;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_PRESSED        = 3'd1,
      ST_LONG_HELD      = 3'd2,
      ST_WAIT_SECOND    = 3'd3,
      ST_SECOND_PRESSED = 3'd4
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESSED   = 2'd1,
      ST_LONG_HELD = 2'd2
   } state_t;
`endif

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/level_edge_detect.sv
// Rise/fall pulses from a level against its registered previous value; zero latency, no backpressure.
// The previous level loads the input during reset too, so a level held through reset yields no edge.
module level_edge_detect (
   input  logic clk,
   input  logic rst_l,
   input  logic level,
   output logic rise,
   output logic fall
);

   logic prev;

   always_ff @(posedge clk) begin
      prev <= level;
   end

   assign rise = rst_l &  level & ~prev;
   assign fall = rst_l & ~level &  prev;

endmodule

// File: rtl/button_event_decoder.sv
// Button gesture decoder: press/release/short/long/double-click pulses, registered one cycle after the sampled event.
// No backpressure; BUTTON_EVENT_DOUBLE_CLICK_EN enables the double-click window states.
module button_event_decoder
   import button_event_pkg::*;
#(
   parameter int unsigned LONG_PRESS_TIME     = DEF_LONG_PRESS_TIME,
   parameter int unsigned DOUBLE_CLICK_WINDOW = DEF_DOUBLE_CLICK_WINDOW,
   parameter int unsigned CNT_WIDTH           = DEF_CNT_WIDTH
)(
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Press,
   output logic o_Release,
   output logic o_Short_Click,
   output logic o_Long_Press,
   output logic o_Double_Click
);

   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_TIME - 1);
   // Saturating at the largest threshold keeps the timer from wrapping back into a match.
   localparam logic [CNT_WIDTH-1:0] TIMER_SAT = CNT_WIDTH'(max_u(LONG_PRESS_TIME, DOUBLE_CLICK_WINDOW));
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam logic [CNT_WIDTH-1:0] WIN_LAST  = CNT_WIDTH'(DOUBLE_CLICK_WINDOW - 1);
`endif

   logic                 rise;
   logic                 fall;
   state_t               state;
   state_t               state_next;
   logic [CNT_WIDTH-1:0] timer;
   logic                 press_nxt;
   logic                 release_nxt;
   logic                 short_nxt;
   logic                 long_nxt;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   logic                 double_nxt;
`endif

   level_edge_detect u_edge (
      .clk   (i_Clk),
      .rst_l (i_Rst_L),
      .level (i_Switch),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      state_next  = state;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      short_nxt   = 1'b0;
      long_nxt    = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      double_nxt  = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (rise) begin
               state_next = ST_PRESSED;
               press_nxt  = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (fall) begin
               release_nxt = 1'b1;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
               state_next  = ST_WAIT_SECOND;
`else
               state_next  = ST_IDLE;
               short_nxt   = 1'b1;
`endif
            end else if (timer == LONG_LAST) begin
               state_next = ST_LONG_HELD;
               long_nxt   = 1'b1;
            end
         end
         ST_LONG_HELD: begin
            if (fall) begin
               state_next  = ST_IDLE;
               release_nxt = 1'b1;
            end
         end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
         ST_WAIT_SECOND: begin
            // A press landing on the timeout cycle wins over the single click.
            if (rise) begin
               state_next = ST_SECOND_PRESSED;
               press_nxt  = 1'b1;
            end else if (timer == WIN_LAST) begin
               state_next = ST_IDLE;
               short_nxt  = 1'b1;
            end
         end
         ST_SECOND_PRESSED: begin
            if (fall) begin
               state_next  = ST_IDLE;
               release_nxt = 1'b1;
               double_nxt  = 1'b1;
            end else if (timer == LONG_LAST) begin
               state_next = ST_LONG_HELD;
               long_nxt   = 1'b1;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state         <= ST_IDLE;
         timer         <= '0;
         o_Press       <= 1'b0;
         o_Release     <= 1'b0;
         o_Short_Click <= 1'b0;
         o_Long_Press  <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            timer <= '0;
         end else if (timer != TIMER_SAT) begin
            timer <= timer + CNT_WIDTH'(1);
         end
         o_Press       <= press_nxt;
         o_Release     <= release_nxt;
         o_Short_Click <= short_nxt;
         o_Long_Press  <= long_nxt;
      end
   end

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         o_Double_Click <= 1'b0;
      end else begin
         o_Double_Click <= double_nxt;
      end
   end
`else
   assign o_Double_Click = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder at LONG_PRESS_TIME=20, DOUBLE_CLICK_WINDOW=10.
// Expectations follow BUTTON_EVENT_DOUBLE_CLICK_EN as seen at compile time.
module tb_button_event_decoder;

   localparam int LPT = 20;
   localparam int DCW = 10;

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_l = 1'b0;
   logic sw    = 1'b0;
   logic press, rel, short_click, long_press, double_click;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int n_press, n_rel, n_short, n_long, n_dbl;
   int n_multi = 0;
   int c_press, c_press1, c_rel, c_short, c_short1, c_long, c_dbl;

   button_event_decoder #(
      .LONG_PRESS_TIME     (LPT),
      .DOUBLE_CLICK_WINDOW (DCW),
      .CNT_WIDTH           (5)
   ) dut (
      .i_Clk          (clk),
      .i_Rst_L        (rst_l),
      .i_Switch       (sw),
      .o_Press        (press),
      .o_Release      (rel),
      .o_Short_Click  (short_click),
      .o_Long_Press   (long_press),
      .o_Double_Click (double_click)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Pulse log, sampled mid-cycle.
   always @(negedge clk) begin
      if (press)        begin if (n_press == 0) c_press1 = cyc; c_press = cyc; n_press++; end
      if (rel)          begin c_rel = cyc; n_rel++; end
      if (short_click)  begin if (n_short == 0) c_short1 = cyc; c_short = cyc; n_short++; end
      if (long_press)   begin c_long = cyc; n_long++; end
      if (double_click) begin c_dbl = cyc; n_dbl++; end
      if (int'(short_click) + int'(long_press) + int'(double_click) > 1) n_multi++;
   end

   task automatic clr();
      n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_dbl = 0;
      c_press = -1; c_press1 = -1; c_rel = -1; c_short = -1; c_short1 = -1; c_long = -1; c_dbl = -1;
   endtask

   task automatic drive(input logic v, input int n);
      sw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_l = 1'b0;
      drive(1'b0, 3);
      compared++;
      if ({press, rel, short_click, long_press, double_click} !== 5'b0) begin
         mismatched++; $display("FAIL reset_outs_sw0: got %b want 00000", {press, rel, short_click, long_press, double_click});
      end
      drive(1'b1, 3);
      compared++;
      if ({press, rel, short_click, long_press, double_click} !== 5'b0) begin
         mismatched++; $display("FAIL reset_outs_sw1: got %b want 00000", {press, rel, short_click, long_press, double_click});
      end
      drive(1'b0, 2);
      rst_l = 1'b1;
      drive(1'b0, 5);
   endtask

   task automatic test_short_click();
      clr();
      drive(1'b1, 5);
      drive(1'b0, 15);
      compared++; if (n_press !== 1) begin mismatched++; $display("FAIL short_press_cnt: got %0d want 1", n_press); end
      compared++; if (n_rel !== 1) begin mismatched++; $display("FAIL short_rel_cnt: got %0d want 1", n_rel); end
      compared++; if (c_rel - c_press !== 5) begin mismatched++; $display("FAIL short_rel_delay: got %0d want 5", c_rel - c_press); end
      compared++; if (n_short !== 1) begin mismatched++; $display("FAIL short_cnt: got %0d want 1", n_short); end
      compared++;
      if (c_short - c_rel !== (DBL ? DCW : 0)) begin
         mismatched++; $display("FAIL short_delay: got %0d want %0d", c_short - c_rel, DBL ? DCW : 0);
      end
      compared++;
      if (n_long + n_dbl !== 0) begin mismatched++; $display("FAIL short_other: got %0d want 0", n_long + n_dbl); end
   endtask

   task automatic test_long_press();
      clr();
      drive(1'b1, 30);
      drive(1'b0, 15);
      compared++; if (n_long !== 1) begin mismatched++; $display("FAIL long_cnt: got %0d want 1", n_long); end
      compared++; if (c_long - c_press !== LPT) begin mismatched++; $display("FAIL long_delay: got %0d want %0d", c_long - c_press, LPT); end
      compared++; if (n_rel !== 1) begin mismatched++; $display("FAIL long_rel_cnt: got %0d want 1", n_rel); end
      compared++; if (c_rel - c_press !== 30) begin mismatched++; $display("FAIL long_rel_delay: got %0d want 30", c_rel - c_press); end
      compared++; if (n_short + n_dbl !== 0) begin mismatched++; $display("FAIL long_no_click: got %0d want 0", n_short + n_dbl); end
   endtask

   task automatic test_double_click();
      clr();
      drive(1'b1, 3);
      drive(1'b0, 4);
      drive(1'b1, 3);
      drive(1'b0, 15);
      compared++; if (n_press !== 2) begin mismatched++; $display("FAIL dbl_press_cnt: got %0d want 2", n_press); end
      compared++; if (c_press - c_press1 !== 7) begin mismatched++; $display("FAIL dbl_press_gap: got %0d want 7", c_press - c_press1); end
      compared++; if (n_rel !== 2) begin mismatched++; $display("FAIL dbl_rel_cnt: got %0d want 2", n_rel); end
      compared++; if (n_dbl !== (DBL ? 1 : 0)) begin mismatched++; $display("FAIL dbl_cnt: got %0d want %0d", n_dbl, DBL ? 1 : 0); end
      compared++; if (n_short !== (DBL ? 0 : 2)) begin mismatched++; $display("FAIL dbl_short_cnt: got %0d want %0d", n_short, DBL ? 0 : 2); end
      compared++;
      if (DBL ? (c_dbl !== c_rel) : (c_short !== c_rel)) begin
         mismatched++; $display("FAIL dbl_with_release: got dbl=%0d short=%0d want rel=%0d", c_dbl, c_short, c_rel);
      end
      compared++; if (c_rel - c_press1 !== 10) begin mismatched++; $display("FAIL dbl_rel_time: got %0d want 10", c_rel - c_press1); end
   endtask

   task automatic test_window_edge();
      // Second press edge lands on the timeout cycle.
      clr();
      drive(1'b1, 3);
      drive(1'b0, DCW);
      drive(1'b1, 3);
      drive(1'b0, 15);
      compared++; if (n_press !== 2) begin mismatched++; $display("FAIL edge_press_cnt: got %0d want 2", n_press); end
      compared++; if (n_dbl !== (DBL ? 1 : 0)) begin mismatched++; $display("FAIL edge_dbl_cnt: got %0d want %0d", n_dbl, DBL ? 1 : 0); end
      compared++; if (n_short !== (DBL ? 0 : 2)) begin mismatched++; $display("FAIL edge_short_cnt: got %0d want %0d", n_short, DBL ? 0 : 2); end
      // One cycle later the window has already closed.
      clr();
      drive(1'b1, 3);
      drive(1'b0, DCW + 1);
      drive(1'b1, 3);
      drive(1'b0, 15);
      compared++; if (n_dbl !== 0) begin mismatched++; $display("FAIL late_dbl_cnt: got %0d want 0", n_dbl); end
      compared++; if (n_short !== 2) begin mismatched++; $display("FAIL late_short_cnt: got %0d want 2", n_short); end
      compared++;
      if (c_short1 - c_press1 !== (DBL ? 13 : 3)) begin
         mismatched++; $display("FAIL late_short1_time: got %0d want %0d", c_short1 - c_press1, DBL ? 13 : 3);
      end
      compared++; if (c_press - c_press1 !== 14) begin mismatched++; $display("FAIL late_press_gap: got %0d want 14", c_press - c_press1); end
   endtask

   task automatic test_held_through_reset();
      sw    = 1'b1;
      rst_l = 1'b0;
      drive(1'b1, 3);
      rst_l = 1'b1;
      clr();
      drive(1'b1, 10);
      drive(1'b0, 15);
      compared++;
      if (n_press + n_rel + n_short + n_long + n_dbl !== 0) begin
         mismatched++; $display("FAIL held_reset_pulses: got %0d want 0", n_press + n_rel + n_short + n_long + n_dbl);
      end
      clr();
      drive(1'b1, 4);
      drive(1'b0, 15);
      compared++; if (n_press !== 1) begin mismatched++; $display("FAIL after_reset_press: got %0d want 1", n_press); end
      compared++; if (n_rel !== 1) begin mismatched++; $display("FAIL after_reset_rel: got %0d want 1", n_rel); end
      compared++; if (c_rel - c_press !== 4) begin mismatched++; $display("FAIL after_reset_rel_delay: got %0d want 4", c_rel - c_press); end
   endtask

   task automatic test_reset_abort();
      clr();
      drive(1'b1, 10);
      rst_l = 1'b0;
      drive(1'b1, 2);
      rst_l = 1'b1;
      drive(1'b1, 30);
      drive(1'b0, 15);
      drive(1'b1, 3);
      drive(1'b0, 2);
      rst_l = 1'b0;
      drive(1'b0, 2);
      rst_l = 1'b1;
      drive(1'b0, 15);
      compared++; if (n_press !== 2) begin mismatched++; $display("FAIL abort_press_cnt: got %0d want 2", n_press); end
      compared++; if (n_rel !== 1) begin mismatched++; $display("FAIL abort_rel_cnt: got %0d want 1", n_rel); end
      compared++; if (n_long !== 0) begin mismatched++; $display("FAIL abort_long_cnt: got %0d want 0", n_long); end
      compared++; if (n_short !== (DBL ? 0 : 1)) begin mismatched++; $display("FAIL abort_short_cnt: got %0d want %0d", n_short, DBL ? 0 : 1); end
      compared++; if (n_dbl !== 0) begin mismatched++; $display("FAIL abort_dbl_cnt: got %0d want 0", n_dbl); end
   endtask

   initial begin
      clr();
      test_reset();
      test_short_click();
      test_long_press();
      test_double_click();
      test_window_edge();
      test_held_through_reset();
      test_reset_abort();
      compared++;
      if (n_multi !== 0) begin mismatched++; $display("FAIL exclusive_clicks: got %0d overlapping cycles want 0", n_multi); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
